dispense_timer: RTL and testbench
=================================

DISPENSE_TIMER -- requirements
Module: dispense_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000, SHALL set the clock cycles per dispense tick (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Parameter AMT_W, default 8, SHALL set the width of recipe amounts and the tick counter.
REQ-003 clock  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle brew request.
REQ-006 recipe_sel  input  2  recipe index, latched on an accepted start.
REQ-007 stage  input  6  sequencer stage one-hot {finished, chocolate, milk, sugar, coffee, water}, with water as bit 0.
REQ-008 result  output  1  one-cycle pulse meaning "current ingredient amount reached"; it feeds the sequencer advance input.
REQ-009 valve  output  5  one-hot pump enable {chocolate, milk, sugar, coffee, water}.
REQ-010 busy  output  1  high from an accepted start until finished is seen or a fault occurs.
REQ-011 fault  output  1  sticky illegal-stage indicator.

Function
REQ-012 States SHALL be IDLE, ARM, DISPENSE, REPORT, WAIT and FAULT.
REQ-013 IDLE: start=1 with stage==water SHALL latch recipe_sel and go to ARM.
- start is ignored in every other state.
- start is ignored in IDLE while stage is not water.
REQ-014 ARM, one cycle:
- stage not one-hot -> FAULT.
- stage==finished -> IDLE.
- otherwise load target = RECIPE[sel][ingredient], clear the counter and prescaler, and record the stage.
- target==0 -> REPORT (ingredient skipped, valve never opens).
- target>0 -> DISPENSE.
REQ-015 DISPENSE: the valve bit of the recorded ingredient SHALL be high; the counter SHALL increment on each tick.
REQ-016 DISPENSE exit: when a tick makes count==target, the next state SHALL be REPORT.
REQ-017 DISPENSE stage change: if stage changes during DISPENSE, the block SHALL close the valve and go to ARM without pulsing result.
REQ-018 REPORT: result=1 for exactly one cycle with valves closed; next state WAIT.
REQ-019 WAIT: stage differing from the recorded stage SHALL go to ARM; otherwise remain in WAIT.
REQ-020 FAULT: valve=0, result=0, fault=1, busy=0; FAULT SHALL be left only by reset.
REQ-021 Prescaler: it SHALL emit a one-cycle tick every TICK_DIV cycles and reset to 0 in ARM, so the first tick lands TICK_DIV cycles after DISPENSE entry.
REQ-022 Counter: the counter SHALL be AMT_W bits and never wrap; target is at most 2^AMT_W-1 and equality is checked before increment.
REQ-023 Latency: result SHALL rise exactly 1+TICK_DIV*target cycles after ARM, or 1 cycle after ARM when target==0.
REQ-024 Outputs: valve and result SHALL be registered (glitch-free); at most one valve bit may be high in any cycle.
REQ-025 recipe_sel changes after start SHALL have no effect until the next accepted start.

Reset
REQ-026 Reset SHALL force, asynchronously: state=IDLE, valve=0, result=0, busy=0, fault=0, counter=0, prescaler=0 and latched sel=0.
REQ-027 Reset asserted mid-dispense SHALL close all valves in the same cycle, without waiting for a clock edge.

Structure
REQ-028 Package dispense_pkg SHALL hold:
- the state enum;
- the ingredient index constants;
- the RECIPE table (4 x 5 of AMT_W), with values {water, coffee, sugar, milk, chocolate}:
  - 0 black = {10,4,0,0,0}
  - 1 sweet = {10,4,2,0,0}
  - 2 latte = {6,4,1,5,0}
  - 3 mocha = {6,3,1,3,4}
REQ-029 The prescaler SHALL be a separate sub-module tick_prescaler with inputs clock, reset and clear, and output tick.

Verification (TICK_DIV=4)
REQ-030 Verification SHALL cover these six directed scenarios:
- Black coffee: start with sel=0, sequencer looped back. Required: valve[0] high for 40 cycles, result at ARM+41, then coffee for 16 cycles; sugar, milk and chocolate skipped with result 1 cycle after ARM; busy drops when finished is seen.
- Mocha: chocolate valve open for exactly 16 cycles; total valve-open cycles 68; never two valves high at once.
- Reset at cycle 20 of the water dispense: valve=0 immediately; then IDLE; a new start restarts water from a count of 0.
- stage=6'b000011 presented in ARM: fault=1, valves closed, no result; start ignored until reset.
- start while busy, or recipe_sel toggled mid-brew: no effect; amounts follow the latched recipe.
- start with stage==coffee in IDLE: ignored; busy stays 0.

Source files
------------

// File: rtl/dispense_pkg.sv
// Shared definitions for the dispense timer: controller states, ingredient
// indices, stage encoding and the per-recipe dispense amounts (in ticks).
package dispense_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_DISPENSE,
    S_REPORT,
    S_WAIT,
    S_FAULT
  } state_t;

  localparam int NUM_ING    = 5;
  localparam int ING_WATER  = 0;
  localparam int ING_COFFEE = 1;
  localparam int ING_SUGAR  = 2;
  localparam int ING_MILK   = 3;
  localparam int ING_CHOC   = 4;

  // Stage bit 5 is the sequencer's "finished" marker; bits 4..0 line up with valves.
  localparam int         STAGE_FINISHED = 5;
  localparam logic [5:0] STAGE_WATER    = 6'b000001;

  // Amounts per recipe, ordered {water, coffee, sugar, milk, chocolate}.
  localparam int unsigned RECIPE [4][NUM_ING] = '{
    '{10, 4, 0, 0, 0},   // 0 black
    '{10, 4, 2, 0, 0},   // 1 sweet
    '{ 6, 4, 1, 5, 0},   // 2 latte
    '{ 6, 3, 1, 3, 4}    // 3 mocha
  };

  // Ingredient index of a one-hot stage; only meaningful for bits 4..0.
  function automatic logic [2:0] stage_to_ing(input logic [5:0] stg);
    logic [2:0] ing;
    ing = '0;
    for (int i = 0; i < NUM_ING; i++) begin
      if (stg[i]) ing = 3'(i);
    end
    return ing;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// clear restarts the count so the first tick lands TICK_DIV cycles later.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned    CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  // Divider counter: wraps at TICK_DIV-1, restarts on clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/dispense_timer.sv
// Dispense timer: opens one pump valve per sequencer stage for the number of
// ticks the latched recipe asks for, then pulses result so the sequencer advances.
module dispense_timer
  import dispense_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned AMT_W    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] recipe_sel,
  input  logic [5:0] stage,
  output logic       result,
  output logic [4:0] valve,
  output logic       busy,
  output logic       fault
);

  state_t           r_state, w_state_next;
  logic [1:0]       r_sel;
  logic [5:0]       r_stage;
  logic [AMT_W-1:0] r_target, r_count;
  logic [4:0]       r_valve, w_valve_next;
  logic             r_result, w_result_next;
  logic             r_busy, r_fault;
  logic             w_sel_load, w_arm_load, w_count_inc;
  logic             w_tick, w_clear;
  logic [2:0]       w_ing;
  logic [AMT_W-1:0] w_amount;

  assign w_ing    = stage_to_ing(stage);
  assign w_amount = AMT_W'(RECIPE[r_sel][w_ing]);
  assign w_clear  = (r_state == S_ARM);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Next-state and next-output decode; valve/result are computed one cycle ahead
  // so the registered copies line up with the state they belong to.
  always_comb begin
    w_state_next  = r_state;
    w_valve_next  = '0;
    w_result_next = 1'b0;
    w_sel_load    = 1'b0;
    w_arm_load    = 1'b0;
    w_count_inc   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && (stage == STAGE_WATER)) begin
          w_state_next = S_ARM;
          w_sel_load   = 1'b1;
        end
      end
      S_ARM: begin
        if (!$onehot(stage)) begin
          w_state_next = S_FAULT;
        end else if (stage[STAGE_FINISHED]) begin
          w_state_next = S_IDLE;
        end else begin
          w_arm_load = 1'b1;
          if (w_amount == '0) begin
            w_state_next  = S_REPORT;
            w_result_next = 1'b1;
          end else begin
            w_state_next = S_DISPENSE;
            w_valve_next = stage[4:0];
          end
        end
      end
      S_DISPENSE: begin
        if (stage != r_stage) begin
          // Sequencer moved on under us: close the valve and re-arm silently.
          w_state_next = S_ARM;
        end else if (w_tick) begin
          w_count_inc = 1'b1;
          if (r_count == r_target - 1'b1) begin
            w_state_next  = S_REPORT;
            w_result_next = 1'b1;
          end else begin
            w_valve_next = r_valve;
          end
        end else begin
          w_valve_next = r_valve;
        end
      end
      S_REPORT: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (stage != r_stage) w_state_next = S_ARM;
      end
      S_FAULT: begin
        w_state_next = S_FAULT;
      end
      default: begin
        w_state_next = S_FAULT;
      end
    endcase
  end

  // State and registered outputs; reset closes valves without waiting for a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_valve  <= '0;
      r_result <= 1'b0;
      r_busy   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_valve  <= w_valve_next;
      r_result <= w_result_next;
      r_busy   <= (w_state_next != S_IDLE) && (w_state_next != S_FAULT);
      r_fault  <= r_fault | (w_state_next == S_FAULT);
    end
  end

  // Recipe latch, ingredient target and tick counter (equality checked before increment).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sel    <= '0;
      r_stage  <= '0;
      r_target <= '0;
      r_count  <= '0;
    end else begin
      if (w_sel_load) r_sel <= recipe_sel;
      if (w_arm_load) begin
        r_target <= w_amount;
        r_count  <= '0;
        r_stage  <= stage;
      end else if (w_count_inc) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign valve  = r_valve;
  assign result = r_result;
  assign busy   = r_busy;
  assign fault  = r_fault;

endmodule

// File: tb/tb_dispense_timer.sv
// Bench for dispense_timer with TICK_DIV=4: a brew-level timeline model fills
// per-cycle expectations; a sequencer model advances stage on each result.
module tb_dispense_timer;

  localparam int TD = 4;
  localparam int N  = 1024;

  logic       clock = 1'b0;
  logic       reset, start;
  logic [1:0] recipe_sel;
  logic [5:0] stage;
  logic       result, busy, fault;
  logic [4:0] valve;

  dispense_timer #(.TICK_DIV(TD), .AMT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .recipe_sel (recipe_sel),
    .stage      (stage),
    .result     (result),
    .valve      (valve),
    .busy       (busy),
    .fault      (fault)
  );

  always #5 clock = ~clock;

  // {water, coffee, sugar, milk, chocolate} amounts per recipe.
  int amt_tab [4][5] = '{'{10,4,0,0,0}, '{10,4,2,0,0}, '{6,4,1,5,0}, '{6,3,1,3,4}};

  bit [4:0] exp_valve  [N];
  bit       exp_result [N];
  bit       exp_busy   [N];
  bit       exp_fault  [N];

  int  cyc = 0;
  int  n_pass = 0;
  int  n_total = 0;
  bit  res_seen = 1'b0;
  bit  pend_valid = 1'b0;
  logic [5:0] pend_stage = '0;
  int  valve_on [5];
  int  total_on;
  int  res_q [$];
  int  a, fin;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < N; i++) begin
      exp_valve[i] = '0; exp_result[i] = 1'b0; exp_busy[i] = 1'b0; exp_fault[i] = 1'b0;
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 5; i++) valve_on[i] = 0;
    total_on = 0;
    res_q.delete();
  endtask

  // Whole-brew timeline from the ARM cycle: each ingredient opens its valve for
  // TD*n cycles, result follows, the sequencer advances and re-arm takes 2 more.
  task automatic plan_brew(input int arm, input int sel, output int fin_arm);
    int t;
    t = arm;
    for (int i = 0; i < 5; i++) begin
      int n;
      n = amt_tab[sel][i];
      for (int k = 1; k <= TD * n; k++) exp_valve[t + k] = 5'b00001 << i;
      exp_result[t + TD * n + 1] = 1'b1;
      t = t + TD * n + 3;
    end
    for (int i = arm; i <= t; i++) exp_busy[i] = 1'b1;
    fin_arm = t;
  endtask

  task automatic compare();
    chk("valve",  int'(valve),  int'(exp_valve[cyc]));
    chk("result", int'(result), int'(exp_result[cyc]));
    chk("busy",   int'(busy),   int'(exp_busy[cyc]));
    chk("fault",  int'(fault),  int'(exp_fault[cyc]));
    chk("valve_onehot0", int'($countones(valve) <= 1), 1);
    for (int i = 0; i < 5; i++) valve_on[i] += int'(valve[i]);
    if (valve != '0) total_on++;
    if (result) res_q.push_back(cyc);
  endtask

  // One clock: sequencer reacts after the edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clock);
    cyc++;
    if (cyc >= N) begin
      $display("FAIL cycle_budget exceeded: got %0d cycles, limit %0d", cyc, N);
      $fatal(1, "cycle budget");
    end
    #1;
    if (pend_valid) begin
      stage = pend_stage;
      pend_valid = 1'b0;
    end else if (res_seen && stage != 6'b100000) begin
      stage = stage << 1;
    end
    @(negedge clock);
    compare();
    res_seen = result;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic start_brew(input int sel, output int arm, output int fin_arm);
    recipe_sel = 2'(sel);
    start = 1'b1;
    arm = cyc + 1;
    plan_brew(arm, sel, fin_arm);
    step();
    start = 1'b0;
  endtask

  task automatic loop_back();
    stage = 6'b000001;
    step();
    step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; recipe_sel = '0; stage = 6'b000001;
    #1;
    chk("reset_valve",  int'(valve),  0);
    chk("reset_result", int'(result), 0);
    chk("reset_busy",   int'(busy),   0);
    chk("reset_fault",  int'(fault),  0);
    repeat (2) step();
    reset = 1'b0;
    repeat (2) step();

    // Black coffee
    clr_counts();
    start_brew(0, a, fin);
    run_to(fin + 2);
    chk("black_water_cycles", valve_on[0], 40);
    chk("black_coffee_cycles", valve_on[1], 16);
    chk("black_result_count", res_q.size(), 5);
    chk("black_finish_arm", fin - a, 71);
    if (res_q.size() >= 5) begin
      chk("black_water_result",  res_q[0] - a, 41);
      chk("black_coffee_result", res_q[1] - a, 60);
      chk("black_sugar_result",  res_q[2] - a, 63);
      chk("black_choc_result",   res_q[4] - a, 69);
    end
    loop_back();

    // Reset during water dispense, then restart from zero
    clr_counts();
    start_brew(0, a, fin);
    run_to(a + 20);
    reset = 1'b1;
    #1;
    chk("reset_async_valve", int'(valve), 0);
    chk("reset_async_busy",  int'(busy),  0);
    clear_from(cyc + 1);
    step();
    reset = 1'b0;
    step();
    clr_counts();
    start_brew(0, a, fin);
    run_to(fin + 2);
    chk("restart_water_cycles", valve_on[0], 40);
    if (res_q.size() >= 1) chk("restart_water_result", res_q[0] - a, 41);
    loop_back();

    // Illegal stage presented in ARM
    recipe_sel = 2'd0;
    start = 1'b1;
    pend_stage = 6'b000011;
    pend_valid = 1'b1;
    a = cyc + 1;
    exp_busy[a] = 1'b1;
    for (int i = a + 1; i < N; i++) exp_fault[i] = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("fault_sticky", int'(fault), 1);
    stage = 6'b000001;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("fault_start_ignored_busy", int'(busy), 0);
    reset = 1'b1;
    clear_from(cyc + 1);
    step();
    reset = 1'b0;
    repeat (2) step();
    chk("fault_cleared", int'(fault), 0);

    // Sweet with extra starts and recipe_sel churn during the brew
    clr_counts();
    start_brew(1, a, fin);
    while (cyc < fin + 2) begin
      recipe_sel = cyc[1:0];
      start = (cyc % 5 == 0);
      step();
    end
    start = 1'b0;
    chk("sweet_water_cycles",  valve_on[0], 40);
    chk("sweet_coffee_cycles", valve_on[1], 16);
    chk("sweet_sugar_cycles",  valve_on[2], 8);
    chk("sweet_milk_cycles",   valve_on[3], 0);
    loop_back();

    // Mocha
    clr_counts();
    start_brew(3, a, fin);
    run_to(fin + 2);
    chk("mocha_choc_cycles", valve_on[4], 16);
    chk("mocha_total_open", total_on, 68);
    chk("mocha_finish_arm", fin - a, 83);
    loop_back();

    // Start while stage is coffee in IDLE
    stage = 6'b000010;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("coffee_stage_start_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
